mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the execute stage of the MIPS pipeline; successor to the fixed 32-bit MDU. It holds the HI/LO register pair, runs multiply/divide operations over a configurable number of cycles with a `busy` handshake toward the hazard unit, and supports flushing an in-flight operation on exception. Multiply-accumulate ops (madd/maddu/msub/msubu) are optional. Reads of HI/LO via mfhi/mflo are combinational onto `result`.

---
 rtl/mdu_iter.sv | 248 ++++++++++++++++++++++++
 tb/tb_mdu_iter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// ---------------------------------------------------------------------------
// mdu_iter
//   Iterative multiply/divide unit for the MIPS execute stage. It owns the
//   HI/LO register pair. A launched mult/div/accumulate op holds `busy` high
//   for a fixed number of cycles and then commits its HI/LO result. An
//   in-flight op can be cancelled with `flush`. mfhi/mflo reads are
//   combinational onto `result`.
//
//   Optional feature: define MDU_MADD_EN to enable madd/maddu/msub/msubu
//   (MDOp 9-12). Without it those opcodes act as "none" and the accumulate
//   datapath is not built.
//
// Parameters
//   WIDTH        operand / HI / LO width
//   MULT_CYCLES  busy cycles for mult/multu/madd*/msub* (>= 1)
//   DIV_CYCLES   busy cycles for div/divu (>= 1)
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   start   in   launch the compute op on MDOp this cycle
//   flush   in   cancel in-flight op; suppress this cycle's launch/write
//   MDOp    in   4-bit opcode (1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,
//                7 mthi,8 mtlo,9 madd,10 maddu,11 msub,12 msubu)
//   D1      in   rs operand (multiplicand / dividend / mthi,mtlo data)
//   D2      in   rt operand (multiplier / divisor)
//   busy    out  operation in flight
//   result  out  HI when MDOp=5, LO when MDOp=6, else 0
// ---------------------------------------------------------------------------
module mdu_iter #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       MDOp,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  output logic             busy,
  output logic [WIDTH-1:0] result
);

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_nextState;
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        w_nextCount;
  logic [3:0]           r_op;
  logic [2*WIDTH-1:0]   r_pend;
  logic                 r_divZero;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     w_nextHi;
  logic [WIDTH-1:0]     w_nextLo;

  logic                 w_isMul;
  logic                 w_isDiv;
  logic                 w_isAcc;
  logic                 w_launch;
  logic                 w_mulSigned;
  logic [2*WIDTH-1:0]   w_opA;
  logic [2*WIDTH-1:0]   w_opB;
  logic [2*WIDTH-1:0]   w_product;

  logic                 w_divSigned;
  logic                 w_negA;
  logic                 w_negB;
  logic [WIDTH-1:0]     w_absA;
  logic [WIDTH-1:0]     w_absB;
  logic [WIDTH-1:0]     w_divisor;
  logic [WIDTH-1:0]     w_quoU;
  logic [WIDTH-1:0]     w_remU;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [2*WIDTH-1:0]   w_pendIn;

  // Opcode classification. Accumulate ops only count as launchable when the
  // accumulate feature is built in.
  always_comb begin
    w_isMul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
    w_isDiv = (MDOp == OP_DIV)  || (MDOp == OP_DIVU);
`ifdef MDU_MADD_EN
    w_isAcc = (MDOp == OP_MADD) || (MDOp == OP_MADDU) ||
              (MDOp == OP_MSUB) || (MDOp == OP_MSUBU);
    w_mulSigned = (MDOp == OP_MULT) || (MDOp == OP_MADD) || (MDOp == OP_MSUB);
`else
    w_isAcc = 1'b0;
    w_mulSigned = (MDOp == OP_MULT);
`endif
  end

  // A launch needs an idle unit and no flush; flush always wins over start.
  assign w_launch = start && !flush && (r_state == S_IDLE) &&
                    (w_isMul || w_isDiv || w_isAcc);

  // Multiplier: operands are extended to 2*WIDTH so the low 2*WIDTH bits of
  // the product are correct for both signed and unsigned interpretations.
  always_comb begin
    w_opA     = w_mulSigned ? {{WIDTH{D1[WIDTH-1]}}, D1} : {{WIDTH{1'b0}}, D1};
    w_opB     = w_mulSigned ? {{WIDTH{D2[WIDTH-1]}}, D2} : {{WIDTH{1'b0}}, D2};
    w_product = w_opA * w_opB;
  end

  // Divider: signed division is done on magnitudes and the signs are fixed up
  // afterwards. The quotient truncates toward zero and the remainder follows
  // the dividend. Most-negative / -1 falls out naturally: the unsigned
  // magnitude quotient 2^(WIDTH-1) reads back as the most-negative value.
  // A zero divisor is swapped for 1 so the datapath never sees an undefined
  // divide; the result is discarded at commit anyway.
  always_comb begin
    w_divSigned = (MDOp == OP_DIV);
    w_negA      = w_divSigned && D1[WIDTH-1];
    w_negB      = w_divSigned && D2[WIDTH-1];
    w_absA      = w_negA ? (-D1) : D1;
    w_absB      = w_negB ? (-D2) : D2;
    w_divisor   = (D2 == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : w_absB;
    w_quoU      = w_absA / w_divisor;
    w_remU      = w_absA % w_divisor;
    w_quo       = (w_negA ^ w_negB) ? (-w_quoU) : w_quoU;
    w_rem       = w_negA ? (-w_remU) : w_remU;
    w_pendIn    = w_isDiv ? {w_rem, w_quo} : w_product;
  end

  // State, counter, HI/LO and the latched operation. The pending value is
  // captured at launch and only folded into HI/LO at the commit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_count   <= '0;
      r_op      <= OP_NONE;
      r_pend    <= '0;
      r_divZero <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      r_hi    <= w_nextHi;
      r_lo    <= w_nextLo;
      if (w_launch) begin
        r_op      <= MDOp;
        r_pend    <= w_pendIn;
        r_divZero <= w_isDiv && (D2 == '0);
      end
    end
  end

  // Next-state logic. IDLE handles launches and mthi/mtlo writes; RUN counts
  // down and commits on the edge where the counter goes from 1 to 0, so busy
  // covers exactly the configured number of cycles.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_count;
    w_nextHi    = r_hi;
    w_nextLo    = r_lo;
    case (r_state)
      S_IDLE: begin
        if (w_launch) begin
          w_nextState = S_RUN;
          w_nextCount = w_isDiv ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (!flush) begin
          if (MDOp == OP_MTHI) begin
            w_nextHi = D1;
          end else if (MDOp == OP_MTLO) begin
            w_nextLo = D1;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          w_nextState = S_IDLE;
          w_nextCount = '0;
        end else if (r_count == CW'(1)) begin
          w_nextState = S_IDLE;
          w_nextCount = '0;
          case (r_op)
            OP_MULT, OP_MULTU: begin
              {w_nextHi, w_nextLo} = r_pend;
            end
            OP_DIV, OP_DIVU: begin
              if (!r_divZero) begin
                {w_nextHi, w_nextLo} = r_pend;
              end
            end
`ifdef MDU_MADD_EN
            // Accumulate against the HI/LO value present at commit time.
            OP_MADD, OP_MADDU: begin
              {w_nextHi, w_nextLo} = {r_hi, r_lo} + r_pend;
            end
            OP_MSUB, OP_MSUBU: begin
              {w_nextHi, w_nextLo} = {r_hi, r_lo} - r_pend;
            end
`endif
            default: begin
              w_nextHi = r_hi;
              w_nextLo = r_lo;
            end
          endcase
        end else begin
          w_nextCount = r_count - CW'(1);
        end
      end
      default: begin
        w_nextState = S_IDLE;
        w_nextCount = '0;
      end
    endcase
  end

  assign busy = (r_state == S_RUN);

  // mfhi/mflo read path; shows the pre-op value while an op is in flight.
  always_comb begin
    result = '0;
    if (MDOp == OP_MFHI) begin
      result = r_hi;
    end else if (MDOp == OP_MFLO) begin
      result = r_lo;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// ---------------------------------------------------------------------------
// tb_mdu_iter
//   Scoreboard bench for mdu_iter (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
//   Stimulus pushes expected mfhi/mflo values and expected busy-run lengths
//   into queues; a negedge monitor pops and compares them as the DUT presents
//   reads or ends a busy period. Honors MDU_MADD_EN like the design.
// ---------------------------------------------------------------------------
module tb_mdu_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic        flush;
  logic [3:0]  MDOp;
  logic [31:0] D1;
  logic [31:0] D2;
  logic        busy;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  logic [31:0] expQ[$];
  string       nameQ[$];
  int          busyQ[$];
  int          busyRun = 0;
  logic [31:0] monExp;
  string       monName;
  int          monLen;

  mdu_iter #(
    .WIDTH(32),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .flush(flush),
    .MDOp(MDOp),
    .D1(D1),
    .D2(D2),
    .busy(busy),
    .result(result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point shared by the monitor and the direct checks.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: compares reads when the DUT presents one and checks the length
  // of every busy period when it ends.
  always @(negedge clk) begin
    if (MDOp == 4'd5 || MDOp == 4'd6) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedRead: got 0x%08h expected no read", result);
      end else begin
        monExp  = expQ.pop_front();
        monName = nameQ.pop_front();
        checkOutput(monName, result, monExp);
      end
    end
    if (busy === 1'b1) begin
      busyRun++;
    end else if (busyRun > 0) begin
      if (busyQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpectedBusy: got run of %0d expected none", busyRun);
      end else begin
        monLen = busyQ.pop_front();
        checkOutput("busyLen", busyRun, monLen);
      end
      busyRun = 0;
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] d1,
                               input logic [31:0] d2, input logic st, input logic fl);
    MDOp  = op;
    D1    = d1;
    D2    = d2;
    start = st;
    flush = fl;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    MDOp  = 4'd0;
  endtask

  task automatic readReg(input logic [3:0] sel, input logic [31:0] exp, input string name);
    MDOp = sel;
    expQ.push_back(exp);
    nameQ.push_back(name);
    @(posedge clk);
    #1;
    MDOp = 4'd0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got busy after %0d cycles expected idle", name, budget);
    end
  endtask

  task automatic expectNoBusy(input int cycles, input string name);
    int hits;
    hits = 0;
    repeat (cycles) begin
      if (busy !== 1'b0) hits++;
      @(posedge clk);
      #1;
    end
    checkOutput(name, hits, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    MDOp  = 4'd0;
    D1    = '0;
    D2    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state.
    checkOutput("rstBusy", {31'b0, busy}, 32'd0);
    readReg(4'd5, 32'h0, "rstHi");
    readReg(4'd6, 32'h0, "rstLo");

    // Signed mult -3 * 7; HI reads the old value while busy.
    busyQ.push_back(5);
    applyStimulus(4'd1, 32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0);
    readReg(4'd5, 32'h0, "mulPreHi");
    waitIdle(20, "mulTimeout");
    readReg(4'd5, 32'hFFFF_FFFF, "mulHi");
    readReg(4'd6, 32'hFFFF_FFEB, "mulLo");

    // Unsigned divide.
    busyQ.push_back(10);
    applyStimulus(4'd4, 32'hFFFF_FFFF, 32'h10, 1'b1, 1'b0);
    waitIdle(30, "divuTimeout");
    readReg(4'd5, 32'h0000_000F, "divuHi");
    readReg(4'd6, 32'h0FFF_FFFF, "divuLo");

    // Signed divide -7/2, then a back-to-back divu 100/7 launched in the
    // cycle busy falls; the div result is read while the divu is running.
    busyQ.push_back(10);
    applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
    waitIdle(30, "divTimeout");
    busyQ.push_back(10);
    applyStimulus(4'd4, 32'd100, 32'd7, 1'b1, 1'b0);
    readReg(4'd5, 32'hFFFF_FFFF, "divHi");
    readReg(4'd6, 32'hFFFF_FFFD, "divLo");
    waitIdle(30, "b2bTimeout");
    readReg(4'd5, 32'd2, "b2bHi");
    readReg(4'd6, 32'd14, "b2bLo");

    // Most-negative / -1.
    busyQ.push_back(10);
    applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
    waitIdle(30, "ovfTimeout");
    readReg(4'd5, 32'h0, "ovfHi");
    readReg(4'd6, 32'h8000_0000, "ovfLo");

    // mthi/mtlo, then mult flushed in its third busy cycle.
    applyStimulus(4'd7, 32'h1234, 32'd0, 1'b0, 1'b0);
    applyStimulus(4'd8, 32'h0, 32'd0, 1'b0, 1'b0);
    busyQ.push_back(3);
    applyStimulus(4'd1, 32'd3, 32'd4, 1'b1, 1'b0);
    step(2);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checkOutput("flushBusy", {31'b0, busy}, 32'd0);
    readReg(4'd5, 32'h1234, "flushHi");
    readReg(4'd6, 32'h0, "flushLo");

    // mtlo, a flushed mthi (suppressed), then div by zero with an mthi
    // attempted while busy (ignored).
    applyStimulus(4'd8, 32'h55, 32'd0, 1'b0, 1'b0);
    applyStimulus(4'd7, 32'hBEEF, 32'd0, 1'b0, 1'b1);
    busyQ.push_back(10);
    applyStimulus(4'd3, 32'd9, 32'd0, 1'b1, 1'b0);
    applyStimulus(4'd7, 32'hDEAD, 32'd0, 1'b0, 1'b0);
    waitIdle(30, "dz0Timeout");
    readReg(4'd5, 32'h1234, "divZeroHi");
    readReg(4'd6, 32'h55, "divZeroLo");

    // start and flush on the same edge: nothing launches.
    applyStimulus(4'd1, 32'd3, 32'd4, 1'b1, 1'b1);
    expectNoBusy(7, "sameEdgeBusy");
    readReg(4'd6, 32'h55, "sameEdgeLo");

    // Accumulate ops.
    applyStimulus(4'd7, 32'h0, 32'd0, 1'b0, 1'b0);
    applyStimulus(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
    busyQ.push_back(5);
    applyStimulus(4'd10, 32'd1, 32'd1, 1'b1, 1'b0);
    waitIdle(20, "maddTimeout");
    readReg(4'd5, 32'h1, "maddHi");
    readReg(4'd6, 32'h0, "maddLo");
    busyQ.push_back(5);
    applyStimulus(4'd11, 32'd1, 32'd1, 1'b1, 1'b0);
    waitIdle(20, "msubTimeout");
    readReg(4'd5, 32'h0, "msubHi");
    readReg(4'd6, 32'hFFFF_FFFF, "msubLo");
`else
    applyStimulus(4'd10, 32'd1, 32'd1, 1'b1, 1'b0);
    expectNoBusy(7, "maddOffBusy");
    readReg(4'd5, 32'h0, "maddOffHi");
    readReg(4'd6, 32'hFFFF_FFFF, "maddOffLo");
`endif

    // Async reset in the fourth busy cycle of a div.
    applyStimulus(4'd7, 32'h77, 32'd0, 1'b0, 1'b0);
    busyQ.push_back(3);
    applyStimulus(4'd3, 32'd100, 32'd3, 1'b1, 1'b0);
    step(3);
    reset = 1'b1;
    #1;
    checkOutput("rstMidBusy", {31'b0, busy}, 32'd0);
    MDOp = 4'd5;
    #1;
    checkOutput("rstMidHi", result, 32'h0);
    MDOp = 4'd6;
    #1;
    checkOutput("rstMidLo", result, 32'h0);
    MDOp = 4'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Normal operation after reset.
    busyQ.push_back(5);
    applyStimulus(4'd1, 32'd2, 32'd3, 1'b1, 1'b0);
    waitIdle(20, "postRstTimeout");
    readReg(4'd5, 32'h0, "postRstHi");
    readReg(4'd6, 32'd6, "postRstLo");

    step(2);
    while (expQ.size() > 0) begin
      monName = nameQ.pop_front();
      monExp  = expQ.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL %s: got no read expected 0x%08h", monName, monExp);
    end
    while (busyQ.size() > 0) begin
      monLen = busyQ.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL busyLen: got no busy period expected %0d", monLen);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #200000;
    total++;
    bad++;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
